// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared definitions for the multi-cycle RV32I-subset core.
//   - RV32I opcode / funct3 / funct7 constants for the supported subset
//   - FSM state enum and ALU operation enum
//   - get_imm(): builds the sign-extended 32-bit I/S/B/J immediate from an instruction word
package mc_core_pkg;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Beq    = 3'b000;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Sub  = 7'b0100000;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSlt
    } alu_op_e;

    // Immediate format is chosen by opcode; R-type and unknown opcodes yield 0.
    function automatic logic [31:0] get_imm(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            OpcOpImm, OpcLoad: imm = {{20{ir[31]}}, ir[31:20]};
            OpcStore:          imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OpcBranch:         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OpcJal:            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:           imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_core_top_regfile.sv
// mc_regfile: NREGS x XLEN architectural register file.
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low clear of all registers
//   raddr_a_i  read index A (5 bit); indices >= NREGS and x0 read 0
//   raddr_b_i  read index B (5 bit)
//   rdata_a_o  asynchronous read data A
//   rdata_b_o  asynchronous read data B
//   we_i       write enable
//   waddr_i    write index; x0 and indices >= NREGS are dropped
//   wdata_i    write data
module mc_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr_a_i,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] regs_q [NREGS];

    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && (32'(idx) < NREGS);
    endfunction

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (idx_ok(raddr_a_i)) rdata_a_o = regs_q[raddr_a_i[IdxW-1:0]];
        if (idx_ok(raddr_b_i)) rdata_b_o = regs_q[raddr_b_i[IdxW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (we_i && idx_ok(waddr_i)) begin
            regs_q[waddr_i[IdxW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mc_core_top.sv
// mc_core_top: multi-cycle RV32I-subset core (ADD SUB AND OR XOR SLT ADDI LW SW BEQ JAL).
// Fetch and data access share one req/ack memory port; any other opcode halts the core.
//   Clk        clock, rising edge
//   Reset      synchronous active-low reset
//   MemReq     memory request, held until MemAck
//   MemWR      1 = write, 0 = read
//   MemAddr    word address (byte_addr[ADDR_W+1:2])
//   MemWData   store data
//   MemRData   read data, valid with MemAck
//   MemAck     completes the current request
//   PC         current instruction byte address
//   Final_Out  last value written to the register file
//   Retire     one-cycle pulse per completed instruction
//   Halt       sticky halt indicator
// Optional macro MC_CORE_PERF_EN adds CycleCnt / InstrCnt performance counters.
module mc_core_top
    import mc_core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     ADDR_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              MemReq,
    output logic              MemWR,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [XLEN-1:0]   MemWData,
    input  logic [XLEN-1:0]   MemRData,
    input  logic              MemAck,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   Final_Out,
    output logic              Retire,
    output logic              Halt
`ifdef MC_CORE_PERF_EN
    ,
    output logic [XLEN-1:0]   CycleCnt,
    output logic [XLEN-1:0]   InstrCnt
`endif
);

    state_e            state_q, state_d;
    alu_op_e           alu_op_q, dec_alu_op;
    logic              dec_valid;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   pc_q, a_q, b_q, imm_q, pc_imm_q, res_q, mdr_q, final_q;
    logic              take_q;
    logic              mem_req_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [4:0]        rd, rs1, rs2;
    logic              is_op, is_load, is_store, is_branch, is_jal, writes_rd, rd_ok;
    logic [XLEN-1:0]   rf_a, rf_b, rf_wdata, op_b, alu_res, pc_next, imm_x;
    logic              rf_we;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign is_op     = (opcode == OpcOp);
    assign is_load   = (opcode == OpcLoad);
    assign is_store  = (opcode == OpcStore);
    assign is_branch = (opcode == OpcBranch);
    assign is_jal    = (opcode == OpcJal);
    assign writes_rd = is_op || (opcode == OpcOpImm) || is_load || is_jal;
    assign rd_ok     = (rd != 5'd0) && (32'(rd) < NREGS);

    assign imm_x = XLEN'($signed(get_imm(ir_q)));

    // Instruction legality and ALU operation.
    always_comb begin
        dec_valid  = 1'b0;
        dec_alu_op = AluAdd;
        case (opcode)
            OpcOp: begin
                if (funct7 == F7Base) begin
                    dec_valid = 1'b1;
                    case (funct3)
                        F3AddSub: dec_alu_op = AluAdd;
                        F3Slt:    dec_alu_op = AluSlt;
                        F3Xor:    dec_alu_op = AluXor;
                        F3Or:     dec_alu_op = AluOr;
                        F3And:    dec_alu_op = AluAnd;
                        default:  dec_valid  = 1'b0;
                    endcase
                end else if (funct7 == F7Sub && funct3 == F3AddSub) begin
                    dec_valid  = 1'b1;
                    dec_alu_op = AluSub;
                end
            end
            OpcOpImm:          dec_valid = (funct3 == F3AddSub);
            OpcLoad, OpcStore: dec_valid = (funct3 == F3Word);
            OpcBranch:         dec_valid = (funct3 == F3Beq);
            OpcJal:            dec_valid = 1'b1;
            default:           dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        op_b = is_op ? b_q : imm_q;
        unique case (alu_op_q)
            AluAdd:  alu_res = a_q + op_b;
            AluSub:  alu_res = a_q - op_b;
            AluAnd:  alu_res = a_q & op_b;
            AluOr:   alu_res = a_q | op_b;
            AluXor:  alu_res = a_q ^ op_b;
            AluSlt:  alu_res = ($signed(a_q) < $signed(op_b)) ? XLEN'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    assign pc_next  = take_q ? pc_imm_q : pc_q + XLEN'(4);
    assign rf_we    = (state_q == StWb) && writes_rd;
    assign rf_wdata = is_load ? mdr_q : res_q;

    mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata)
    );

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= StFetch;
        else        state_q <= state_d;
    end

    // FSM next state; MemAck only counts while our request is up
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_req_q && MemAck) state_d = StDecode;
            StDecode: state_d = dec_valid ? StExec : StHalt;
            StExec:   state_d = (is_load || is_store) ? StMem : StWb;
            StMem:    if (mem_req_q && MemAck) state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StHalt;
        endcase
    end

    // FSM outputs
    always_comb begin
        Retire = (state_q == StWb);
        Halt   = (state_q == StHalt);
    end

    // Datapath. The request for the next access is raised on the same edge that enters
    // FETCH (from WB) or MEM (from EXEC) so the port is idle only in DECODE/EXEC/WB.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            pc_imm_q    <= '0;
            res_q       <= '0;
            mdr_q       <= '0;
            final_q     <= '0;
            take_q      <= 1'b0;
            alu_op_q    <= AluAdd;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (!mem_req_q) begin
                        // First fetch after reset.
                        mem_req_q  <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= pc_q[ADDR_W+1:2];
                    end else if (MemAck) begin
                        ir_q      <= MemRData[31:0];
                        mem_req_q <= 1'b0;
                    end
                end
                StDecode: begin
                    a_q      <= rf_a;
                    b_q      <= rf_b;
                    imm_q    <= imm_x;
                    pc_imm_q <= pc_q + imm_x;
                    alu_op_q <= dec_alu_op;
                    take_q   <= 1'b0;
                end
                StExec: begin
                    if (is_load || is_store) begin
                        res_q       <= alu_res;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= is_store;
                        mem_addr_q  <= alu_res[ADDR_W+1:2];
                        mem_wdata_q <= b_q;
                    end else if (is_branch) begin
                        take_q <= (a_q == b_q);
                    end else if (is_jal) begin
                        res_q  <= pc_q + XLEN'(4);
                        take_q <= 1'b1;
                    end else begin
                        res_q <= alu_res;
                    end
                end
                StMem: begin
                    if (MemAck) begin
                        mdr_q     <= MemRData;
                        mem_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                    end
                end
                StWb: begin
                    if (writes_rd && rd_ok) final_q <= rf_wdata;
                    pc_q       <= pc_next;
                    mem_req_q  <= 1'b1;
                    mem_wr_q   <= 1'b0;
                    mem_addr_q <= pc_next[ADDR_W+1:2];
                end
                StHalt: begin
                    mem_req_q <= 1'b0;
                    mem_wr_q  <= 1'b0;
                end
                default: mem_req_q <= 1'b0;
            endcase
        end
    end

    assign MemReq    = mem_req_q;
    assign MemWR     = mem_wr_q;
    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign PC        = pc_q;
    assign Final_Out = final_q;

`ifdef MC_CORE_PERF_EN
    logic [XLEN-1:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + XLEN'(1);
            if (state_q == StWb)   instr_cnt_q <= instr_cnt_q + XLEN'(1);
        end
    end

    assign CycleCnt = cycle_cnt_q;
    assign InstrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_core_top.sv
module tb_mc_core_top;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MemReq, MemWR, MemAck;
    logic [7:0]  MemAddr;
    logic [31:0] MemWData, MemRData, PC, Final_Out;
    logic        Retire, Halt;
`ifdef MC_CORE_PERF_EN
    logic [31:0] CycleCnt, InstrCnt;
`endif

    always #5 Clk = ~Clk;

    mc_core_top dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemReq    (MemReq),
        .MemWR     (MemWR),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .MemAck    (MemAck),
        .PC        (PC),
        .Final_Out (Final_Out),
        .Retire    (Retire),
        .Halt      (Halt)
`ifdef MC_CORE_PERF_EN
        ,
        .CycleCnt  (CycleCnt),
        .InstrCnt  (InstrCnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_rc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural memory: ack arrives lat cycles after the request is raised.
    logic [31:0] mem [256];
    logic        mem_clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ack_force = 1'b0;
    int          lat = 1;
    int          wcnt = 0;
    int          sw_hold = 0;

    assign MemAck   = (MemReq && (wcnt == lat - 1)) || ack_force;
    assign MemRData = mem[MemAddr];

    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (MemReq && MemWR && MemAck) begin
            mem[MemAddr] <= MemWData;
        end
        if (!MemReq || MemAck) wcnt <= 0;
        else                   wcnt <= wcnt + 1;
    end

    always @(negedge Clk) begin
        if (MemReq && MemWR && MemAddr == 8'd1 && MemWData == 32'd12) sw_hold <= sw_hold + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = 8'(a);
        ld_data = d;
        @(negedge Clk);
        ld_en = 1'b0;
    endtask

    task automatic start_phase();
        Reset     = 1'b0;
        ack_force = 1'b0;
        lat       = 1;
        mem_clr   = 1'b1;
        @(negedge Clk);
        mem_clr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " MemReq"}, 32'(MemReq), 32'd0);
        check_eq({tag, " MemWR"}, 32'(MemWR), 32'd0);
        check_eq({tag, " MemAddr"}, 32'(MemAddr), 32'd0);
        check_eq({tag, " MemWData"}, MemWData, 32'd0);
        check_eq({tag, " PC"}, PC, 32'd0);
        check_eq({tag, " Final_Out"}, Final_Out, 32'd0);
        check_eq({tag, " Retire"}, 32'(Retire), 32'd0);
        check_eq({tag, " Halt"}, 32'(Halt), 32'd0);
`ifdef MC_CORE_PERF_EN
        check_eq({tag, " CycleCnt"}, CycleCnt, 32'd0);
        check_eq({tag, " InstrCnt"}, InstrCnt, 32'd0);
`endif
    endtask

    task automatic release_reset();
        Reset   = 1'b1;
        last_rc = cyc;
    endtask

    // Returns on the negedge after the Retire cycle, so WB results are visible.
    task automatic wait_retire(input string tag, input int exp_delta);
        int got = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Retire) begin
                got = cyc - last_rc;
                break;
            end
        end
        check_eq({tag, " retire latency"}, 32'(got), 32'(exp_delta));
        last_rc = cyc;
        @(negedge Clk);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Halt) break;
        end
        check_eq({tag, " Halt"}, 32'(Halt), 32'd1);
    endtask

    task automatic idle_check(input string tag);
        int bad = 0;
`ifdef MC_CORE_PERF_EN
        logic [31:0] cc0 = CycleCnt;
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (MemReq || Retire || !Halt) bad++;
        end
        check_eq({tag, " idle while halted"}, 32'(bad), 32'd0);
`ifdef MC_CORE_PERF_EN
        check_eq({tag, " CycleCnt frozen"}, CycleCnt, cc0);
`endif
    endtask

    initial begin
        bit seen;

        // Phase A: ALU ops at L=1, then SW/LW/ADDI x0 at L=3, then ECALL.
        start_phase();
        check_reset_state("A reset");
        load(0, 32'h00500093);  // ADDI x1,x0,5
        load(1, 32'h00700113);  // ADDI x2,x0,7
        load(2, 32'h002081B3);  // ADD  x3,x1,x2
        load(3, 32'h00302223);  // SW   x3,4(x0)
        load(4, 32'h00402203);  // LW   x4,4(x0)
        load(5, 32'h00900013);  // ADDI x0,x0,9
        load(6, 32'h00000073);  // ECALL
        release_reset();
        wait_retire("A addi1", 4);
        check_eq("A addi1 Final_Out", Final_Out, 32'd5);
        wait_retire("A addi2", 4);
        check_eq("A addi2 Final_Out", Final_Out, 32'd7);
        wait_retire("A add", 4);
        check_eq("A add Final_Out", Final_Out, 32'd12);
        lat = 3;
        wait_retire("A sw", 9);
        check_eq("A sw hold cycles", 32'(sw_hold), 32'd3);
        check_eq("A sw mem[1]", mem[1], 32'd12);
        check_eq("A sw Final_Out", Final_Out, 32'd12);
        wait_retire("A lw", 9);
        check_eq("A lw x4", dut.u_regfile.regs_q[4], 32'd12);
        check_eq("A lw Final_Out", Final_Out, 32'd12);
        wait_retire("A addi x0", 6);
        check_eq("A x0 value", dut.u_regfile.regs_q[0], 32'd0);
        check_eq("A x0 Final_Out", Final_Out, 32'd12);
        wait_halt("A ecall");
        idle_check("A");
`ifdef MC_CORE_PERF_EN
        check_eq("A InstrCnt", InstrCnt, 32'd6);
`endif

        // Phase B: negative imm, SLT, BEQ taken / not taken, SUB, XOR.
        start_phase();
        check_reset_state("B reset");
        load(0, 32'h00500093);  // ADDI x1,x0,5
        load(1, 32'h00700113);  // ADDI x2,x0,7
        load(2, 32'hFFF00393);  // ADDI x7,x0,-1
        load(3, 32'h0013A433);  // SLT  x8,x7,x1
        load(4, 32'h00108463);  // 0x10: BEQ x1,x1,+8
        load(6, 32'h00208463);  // 0x18: BEQ x1,x2,+8
        load(7, 32'h402084B3);  // SUB  x9,x1,x2
        load(8, 32'h0020C533);  // XOR  x10,x1,x2
        load(9, 32'h00000073);  // ECALL
        release_reset();
        wait_retire("B addi1", 4);
        wait_retire("B addi2", 4);
        wait_retire("B addi neg", 4);
        check_eq("B addi neg Final_Out", Final_Out, 32'hFFFF_FFFF);
        wait_retire("B slt", 4);
        check_eq("B slt Final_Out", Final_Out, 32'd1);
        wait_retire("B beq taken", 4);
        check_eq("B beq taken PC", PC, 32'h18);
        check_eq("B beq taken Final_Out", Final_Out, 32'd1);
        wait_retire("B beq not taken", 4);
        check_eq("B beq not taken PC", PC, 32'h1C);
        check_eq("B beq not taken Final_Out", Final_Out, 32'd1);
        wait_retire("B sub", 4);
        check_eq("B sub Final_Out", Final_Out, 32'hFFFF_FFFE);
        wait_retire("B xor", 4);
        check_eq("B xor Final_Out", Final_Out, 32'd2);
        wait_halt("B ecall");

        // Phase C: JAL x5,-4 at PC=0 wraps PC; illegal word at 0xFFFFFFFC halts.
        start_phase();
        check_reset_state("C reset");
        load(0, 32'hFFDFF2EF);    // JAL x5,-4
        load(255, 32'hFFFF_FFFF); // unsupported opcode
        release_reset();
        wait_retire("C jal", 4);
        check_eq("C jal x5", dut.u_regfile.regs_q[5], 32'd4);
        check_eq("C jal PC", PC, 32'hFFFF_FFFC);
        check_eq("C jal Final_Out", Final_Out, 32'd4);
        check_eq("C jal fetch MemAddr", 32'(MemAddr), 32'hFF);
        wait_halt("C illegal");
        idle_check("C");
`ifdef MC_CORE_PERF_EN
        check_eq("C InstrCnt", InstrCnt, 32'd1);
`endif

        // Phase D: reset during the 2nd wait cycle of an LW (L=5), then a stray ack.
        start_phase();
        load(0, 32'h00802203);  // LW x4,8(x0)
        load(2, 32'h0000_1234);
        lat = 5;
        release_reset();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (MemReq && MemAddr == 8'd2) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("D lw reached MEM", 32'(seen), 32'd1);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("D abort MemReq", 32'(MemReq), 32'd0);
        check_eq("D abort PC", PC, 32'd0);
        check_eq("D abort Retire", 32'(Retire), 32'd0);
        Reset     = 1'b1;
        ack_force = 1'b1;
        @(negedge Clk);
        ack_force = 1'b0;
        check_eq("D stray ack ignored MemReq", 32'(MemReq), 32'd1);
        check_eq("D stray ack MemAddr", 32'(MemAddr), 32'd0);
        check_eq("D no write x4", dut.u_regfile.regs_q[4], 32'd0);
        check_eq("D Final_Out", Final_Out, 32'd0);
        check_eq("D no Retire", 32'(Retire), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
